// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and the command word.
package alu_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned CMD_W      = OP_W + 2 * DATA_W;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0111;
    localparam logic [OP_W-1:0] OP_SHL = 4'b1000;
    localparam logic [OP_W-1:0] OP_SHR = 4'b1001;
    localparam logic [OP_W-1:0] OP_ROL = 4'b1010;
    localparam logic [OP_W-1:0] OP_ROR = 4'b1011;
    localparam logic [OP_W-1:0] OP_INC = 4'b1100;
    localparam logic [OP_W-1:0] OP_DEC = 4'b1101;
    localparam logic [OP_W-1:0] OP_LT  = 4'b1110;
    localparam logic [OP_W-1:0] OP_EQ  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Two-entry command FIFO; push is refused while full even if a pop happens on the same edge.
module alu_cmd_fifo
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] push_data,
    input  logic             pop,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers ALU commands, issues one per ISSUE cycle and captures the result with valid/ready.
// Optional divide-by-zero guard enabled by defining DIV_GUARD_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic              res_err
);

    state_e            state;
    cmd_t              in_cmd;
    cmd_t              head_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] cap_data;
    logic              cap_carry;
    logic              cap_zero;

    assign in_cmd   = '{op: in_op, a: in_a, b: in_b};
    assign in_ready = !fifo_full;
    assign fifo_pop = (state == ST_ISSUE);

    alu_cmd_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_cmd),
        .pop       (fifo_pop),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef DIV_GUARD_EN
    logic div_zero;
    assign div_zero  = (alu_sel == OP_DIV) && (alu_b == '0);
    assign cap_data  = div_zero ? '0 : alu_res;
    assign cap_carry = div_zero ? 1'b0 : alu_carry;
`else
    assign cap_data  = alu_res;
    assign cap_carry = alu_carry;
    assign res_err   = 1'b0;
`endif
    assign cap_zero = (cap_data == '0);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
`ifdef DIV_GUARD_EN
            res_err   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a   <= head_cmd.a;
                        alu_b   <= head_cmd.b;
                        alu_sel <= head_cmd.op;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_data  <= cap_data;
                    res_carry <= cap_carry;
                    res_zero  <= cap_zero;
`ifdef DIV_GUARD_EN
                    res_err   <= div_zero;
`endif
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // The pop happened on entry to DONE, so the current head is the next command.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!fifo_empty) begin
                            alu_a   <= head_cmd.a;
                            alu_b   <= head_cmd.b;
                            alu_sel <= head_cmd.op;
                            state   <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU driving alu_res/alu_carry.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_res;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_carry;
    logic        res_zero;
    logic        res_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .res_err   (res_err)
    );

    // Downstream ALU stand-in; divide by zero returns 8'hFF.
    always_comb begin
        alu_res   = 8'h00;
        alu_carry = 1'b0;
        case (alu_sel)
            OP_ADD: {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: {alu_carry, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND: alu_res = alu_a & alu_b;
            OP_EQ:  alu_res = {7'h00, alu_a == alu_b};
            OP_DIV: alu_res = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
            default: alu_res = 8'h00;
        endcase
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic check_res(input string tag, input logic [7:0] data, input logic zero);
        check1({tag, "_valid"}, res_valid, 1'b1);
        check8({tag, "_data"}, res_data, data);
        check1({tag, "_zero"}, res_zero, zero);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        res_ready = 1'b0;
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();

        // Reset state
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_res_valid", res_valid, 1'b0);
        check8("rst_alu_a", alu_a, 8'h00);
        check8("rst_alu_b", alu_b, 8'h00);
        check8("rst_alu_sel", {4'h0, alu_sel}, 8'h00);
        check8("rst_res_data", res_data, 8'h00);
        check1("rst_res_carry", res_carry, 1'b0);
        check1("rst_res_zero", res_zero, 1'b0);
        check1("rst_res_err", res_err, 1'b0);

        // ADD F0+20, accepted on the first edge after reset release
        rst_n     = 1'b1;
        res_ready = 1'b1;
        drive(1'b1, OP_ADD, 8'hF0, 8'h20);
        tick();
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        check1("add_n0_valid", res_valid, 1'b0);
        tick();
        check8("add_alu_a", alu_a, 8'hF0);
        check8("add_alu_b", alu_b, 8'h20);
        check8("add_alu_sel", {4'h0, alu_sel}, {4'h0, OP_ADD});
        check1("add_n1_valid", res_valid, 1'b0);
        tick();
        check_res("add", 8'h10, 1'b0);
        check1("add_carry", res_carry, 1'b1);
        tick();
        check1("add_clear", res_valid, 1'b0);

        // Back-to-back SUB, AND, EQ
        drive(1'b1, OP_SUB, 8'h05, 8'h05);
        tick();
        check1("b2b_ready1", in_ready, 1'b1);
        drive(1'b1, OP_AND, 8'hFF, 8'h0F);
        tick();
        check1("b2b_full", in_ready, 1'b0);
        drive(1'b1, OP_EQ, 8'h07, 8'h07);
        tick();
        check1("b2b_ready_again", in_ready, 1'b1);
        check_res("b2b_sub", 8'h00, 1'b1);
        tick();
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        check1("b2b_gap1", res_valid, 1'b0);
        tick();
        check_res("b2b_and", 8'h0F, 1'b0);
        tick();
        check1("b2b_gap2", res_valid, 1'b0);
        tick();
        check_res("b2b_eq", 8'h01, 1'b0);
        tick();
        check1("b2b_end", res_valid, 1'b0);

        // Backpressure: consumer stalled while three commands are offered
        res_ready = 1'b0;
        drive(1'b1, OP_ADD, 8'h01, 8'h02);
        tick();
        drive(1'b1, OP_ADD, 8'h10, 8'h20);
        tick();
        drive(1'b1, OP_ADD, 8'h0A, 8'h0B);
        tick();
        check_res("bp_first", 8'h03, 1'b0);
        tick();
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        check1("bp_full", in_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check1("bp_hold_valid", res_valid, 1'b1);
            check8("bp_hold_data", res_data, 8'h03);
            check1("bp_hold_ready", in_ready, 1'b0);
        end
        res_ready = 1'b1;
        tick();
        check1("bp_rel_gap1", res_valid, 1'b0);
        tick();
        check_res("bp_second", 8'h30, 1'b0);
        tick();
        check1("bp_rel_gap2", res_valid, 1'b0);
        tick();
        check_res("bp_third", 8'h15, 1'b0);
        tick();
        tick();
        check1("bp_drained_valid", res_valid, 1'b0);
        check1("bp_drained_ready", in_ready, 1'b1);

        // Reset while in ISSUE with a full FIFO
        drive(1'b1, OP_SUB, 8'h09, 8'h03);
        tick();
        drive(1'b1, OP_ADD, 8'h01, 8'h01);
        tick();
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        check1("mr_pre_full", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check1("mr_in_ready", in_ready, 1'b1);
        check1("mr_res_valid", res_valid, 1'b0);
        check8("mr_alu_a", alu_a, 8'h00);
        check8("mr_alu_b", alu_b, 8'h00);
        check8("mr_alu_sel", {4'h0, alu_sel}, 8'h00);
        check8("mr_res_data", res_data, 8'h00);
        check1("mr_res_carry", res_carry, 1'b0);
        check1("mr_res_zero", res_zero, 1'b0);
        check1("mr_res_err", res_err, 1'b0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check1("mr_no_stale", seen, 1'b0);

        // DIV 40/00
        drive(1'b1, OP_DIV, 8'h40, 8'h00);
        tick();
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();
`ifdef DIV_GUARD_EN
        check_res("div0", 8'h00, 1'b1);
        check1("div0_err", res_err, 1'b1);
        check1("div0_carry", res_carry, 1'b0);
`else
        check_res("div0", 8'hFF, 1'b0);
        check1("div0_err", res_err, 1'b0);
`endif
        tick();
        check1("div0_clear", res_valid, 1'b0);

        // DIV 40/08
        drive(1'b1, OP_DIV, 8'h40, 8'h08);
        tick();
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        tick();
        tick();
        check_res("div8", 8'h08, 1'b0);
        check1("div8_err", res_err, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
